// File: rtl/spi_reg_pkg.sv
// Shared constants, frame layout and FSM state type for the SPI register bank.
// Addresses of the control registers that feed the PWM stage.
package spi_reg_pkg;

    localparam int NUM_REGS   = 5;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 1 + ADDR_W + DATA_W;
    localparam int CNT_W      = 5;

    // The counter stops one past a full frame so long frames stay distinguishable.
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'd4;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// One-cycle delay of an already-synchronized level, with rise/fall pulses.
// RESET_VAL is the idle level of the line so reset release does not fake an edge.
module sync_edge_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            din_d <= RESET_VAL;
        end else begin
            din_d <= din;
        end
    end

    assign rise = din & ~din_d;
    assign fall = ~din & din_d;

endmodule

// File: rtl/spi_reg_bank.sv
// Write-only SPI mode-0 target: deserializes 16-bit frames and commits them
// into a small bank of 8-bit control registers for the PWM stage.
module spi_reg_bank
    import spi_reg_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        bit_cnt_next;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [FRAME_BITS-1:0]   shift_next;
    logic [DATA_W-1:0]       reg_q [NUM_REGS];

    logic sclk_rise;
    logic sclk_fall_unused;
    logic ncs_rise;
    logic ncs_fall;
    logic commit;
    logic discard;

    logic              frame_rw;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic              addr_ok;

    sync_edge_detect #(.RESET_VAL(1'b0)) u_sclk_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall_unused)
    );

    sync_edge_detect #(.RESET_VAL(1'b1)) u_ncs_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (ncs),
        .rise (ncs_rise),
        .fall (ncs_fall)
    );

    assign frame_rw   = shift_q[FRAME_BITS-1];
    assign frame_addr = shift_q[FRAME_BITS-2 -: ADDR_W];
    assign frame_data = shift_q[DATA_W-1:0];
    assign addr_ok    = (frame_addr < ADDR_W'(NUM_REGS));

    // ncs_rise is tested before sclk_rise so a coincident clock edge is dropped.
    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_q;
        commit       = 1'b0;
        discard      = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (ncs) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (ncs_fall) begin
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                    shift_next   = '0;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_next = IDLE;
                    if ((bit_cnt != CNT_FULL) || !addr_ok) begin
                        discard = 1'b1;
                    end else if (frame_rw) begin
                        commit = 1'b1;
                    end
                end else if (sclk_rise && !ncs) begin
                    shift_next = {shift_q[FRAME_BITS-2:0], copi};
                    if (bit_cnt != CNT_SAT) begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_IDLE;
            bit_cnt   <= '0;
            shift_q   <= '0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            for (int k = 0; k < NUM_REGS; k++) begin
                reg_q[k] <= '0;
            end
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shift_q   <= shift_next;
            wr_strobe <= commit;
            frame_err <= discard;
            if (commit) begin
                wr_addr <= frame_addr;
                for (int k = 0; k < NUM_REGS; k++) begin
                    if (frame_addr == ADDR_W'(k)) begin
                        reg_q[k] <= frame_data;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[g*DATA_W +: DATA_W] = reg_q[g];
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: drives SPI frames slowly relative to clk
// and checks register contents, strobe/error pulses and pulse counts.
module tb_spi_reg_bank;
    import spi_reg_pkg::*;

    logic                       clk;
    logic                       rst;
    logic                       sclk;
    logic                       copi;
    logic                       ncs;
    logic [NUM_REGS*DATA_W-1:0] regs;
    logic                       wr_strobe;
    logic [ADDR_W-1:0]          wr_addr;
    logic                       frame_err;

    int tests_run = 0;
    int tests_failed = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    int strobe_base;
    int err_base;
    logic [NUM_REGS*DATA_W-1:0] exp_regs;

    spi_reg_bank dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .copi      (copi),
        .ncs       (ncs),
        .regs      (regs),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses last one cycle, so one sample per cycle counts each exactly once.
    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic shift_bit(input logic b);
        copi = b;
        repeat (2) tick();
        sclk = 1'b1;
        repeat (2) tick();
        sclk = 1'b0;
    endtask

    // Sends n bits MSB first, raises ncs and returns one negedge after the
    // clk edge that sees ncs high, i.e. while any result pulse is visible.
    task automatic apply_stimulus(input logic [16:0] bits, input int n);
        ncs = 1'b0;
        repeat (2) tick();
        for (int i = n - 1; i >= 0; i--) begin
            shift_bit(bits[i]);
        end
        repeat (2) tick();
        ncs = 1'b1;
        tick();
    endtask

    task automatic settle();
        repeat (3) tick();
        #1;
    endtask

    task automatic mark_counts();
        strobe_base = strobe_cnt;
        err_base = err_cnt;
    endtask

    initial begin
        rst = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        ncs = 1'b1;
        exp_regs = '0;
        repeat (3) tick();
        check_output("reset_regs", 64'(regs), 64'(exp_regs));
        check_output("reset_strobe", 64'(wr_strobe), 64'd0);
        check_output("reset_addr", 64'(wr_addr), 64'd0);
        check_output("reset_err", 64'(frame_err), 64'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Test 1: duty register write
        mark_counts();
        apply_stimulus(17'h08480, 16);
        check_output("t1_strobe", 64'(wr_strobe), 64'd1);
        check_output("t1_err", 64'(frame_err), 64'd0);
        check_output("t1_addr", 64'(wr_addr), 64'(ADDR_DUTY));
        check_output("t1_reg4", 64'(regs[4*DATA_W +: DATA_W]), 64'h80);
        tick();
        check_output("t1_strobe_low", 64'(wr_strobe), 64'd0);
        exp_regs[4*DATA_W +: DATA_W] = 8'h80;

        // Test 2: back-to-back writes
        mark_counts();
        apply_stimulus(17'h080FF, 16);
        check_output("t2_addr0", 64'(wr_addr), 64'(ADDR_EN_OUT_LO));
        apply_stimulus(17'h081A5, 16);
        check_output("t2_addr1", 64'(wr_addr), 64'(ADDR_EN_OUT_HI));
        settle();
        exp_regs[0 +: DATA_W] = 8'hFF;
        exp_regs[DATA_W +: DATA_W] = 8'hA5;
        check_output("t2_regs", 64'(regs), 64'(exp_regs));
        check_output("t2_strobes", 64'(strobe_cnt - strobe_base), 64'd2);
        check_output("t2_errs", 64'(err_cnt - err_base), 64'd0);

        // Test 3: read frame ignored, out-of-range address rejected
        mark_counts();
        apply_stimulus(17'h00012, 16);
        settle();
        check_output("t3_read_regs", 64'(regs), 64'(exp_regs));
        check_output("t3_read_strobes", 64'(strobe_cnt - strobe_base), 64'd0);
        check_output("t3_read_errs", 64'(err_cnt - err_base), 64'd0);
        apply_stimulus(17'h08512, 16);
        check_output("t3_addr5_err", 64'(frame_err), 64'd1);
        check_output("t3_addr5_strobe", 64'(wr_strobe), 64'd0);
        settle();
        check_output("t3_addr5_regs", 64'(regs), 64'(exp_regs));
        check_output("t3_addr5_errs", 64'(err_cnt - err_base), 64'd1);

        // Test 4: short and long frames
        mark_counts();
        apply_stimulus(17'h04009, 15);
        check_output("t4_short_err", 64'(frame_err), 64'd1);
        apply_stimulus(17'h10025, 17);
        check_output("t4_long_err", 64'(frame_err), 64'd1);
        settle();
        check_output("t4_regs", 64'(regs), 64'(exp_regs));
        check_output("t4_errs", 64'(err_cnt - err_base), 64'd2);
        check_output("t4_strobes", 64'(strobe_cnt - strobe_base), 64'd0);

        // Test 5: reset in the middle of a frame
        ncs = 1'b0;
        repeat (2) tick();
        for (int i = 15; i >= 8; i--) shift_bit(1'(16'h8155 >> i));
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_regs = '0;
        mark_counts();
        for (int i = 7; i >= 0; i--) shift_bit(1'(16'h8155 >> i));
        repeat (2) tick();
        ncs = 1'b1;
        settle();
        check_output("t5_regs_zero", 64'(regs), 64'd0);
        check_output("t5_strobes", 64'(strobe_cnt - strobe_base), 64'd0);
        check_output("t5_errs", 64'(err_cnt - err_base), 64'd0);
        apply_stimulus(17'h08233, 16);
        check_output("t5_strobe", 64'(wr_strobe), 64'd1);
        check_output("t5_addr", 64'(wr_addr), 64'(ADDR_EN_PWM_LO));
        exp_regs[2*DATA_W +: DATA_W] = 8'h33;
        check_output("t5_regs", 64'(regs), 64'(exp_regs));

        // Test 6: last sclk rise lands with the ncs rise
        settle();
        mark_counts();
        ncs = 1'b0;
        repeat (2) tick();
        for (int i = 15; i >= 1; i--) shift_bit(1'(16'h8311 >> i));
        copi = 1'b1;
        repeat (2) tick();
        sclk = 1'b1;
        ncs = 1'b1;
        tick();
        check_output("t6_err", 64'(frame_err), 64'd1);
        check_output("t6_strobe", 64'(wr_strobe), 64'd0);
        sclk = 1'b0;
        settle();
        check_output("t6_regs", 64'(regs), 64'(exp_regs));
        check_output("t6_errs", 64'(err_cnt - err_base), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
